// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: decode constants,
// the control state type and a small decode helper.
package muldiv_unit_pkg;

    // R-type OP opcode and the func7 value that routes an instruction here
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // func3 encodings of the M extension
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        SPECIAL,
        DONE
    } muldiv_state_t;

    // The divide family is exactly the set of encodings with func3[2] set
    function automatic logic is_div_op(input logic [2:0] func3);
        return func3[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. It turns signed operands into
// magnitudes and puts the sign back onto finished results.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed
);

    // Invert-and-increment when negate is set, otherwise pass through
    assign fixed = negate ? ((~value) + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Multiply is shift-add, MUL_STEP
// multiplier bits per cycle; divide is restoring, one quotient bit per cycle.
// Both work on magnitudes, and the sign is applied as the result is written.
// XLEN must be even and >= 8; MUL_STEP must be 1, 2 or 4 and divide XLEN.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    muldiv_state_t state, state_next;

    logic [2:0]        func3_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   divisor;
    logic              neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              div_op;
    logic              div_signed;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   mul_result;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   quo_step;
    logic [XLEN-1:0]   rem_step;
    logic              rem_sel;
    logic [XLEN-1:0]   div_pick;
    logic [XLEN-1:0]   div_fixed;
    logic [XLEN-1:0]   special_result;

    // Launch decode: which operands count as signed, and whether a divide
    // short-circuits through the one-cycle special path
    assign accept     = start_i && !flush_i && (state == IDLE || state == DONE);
    assign div_op     = is_div_op(func3_i);
    assign div_signed = (func3_i == FUNCT3_DIV) || (func3_i == FUNCT3_REM);
    assign a_signed   = div_op ? div_signed : (func3_i != FUNCT3_MULHU);
    assign b_signed   = div_op ? div_signed
                               : (func3_i == FUNCT3_MUL) || (func3_i == FUNCT3_MULH);
    assign a_neg      = a_signed && rs1_i[XLEN-1];
    assign b_neg      = b_signed && rs2_i[XLEN-1];
    assign div_zero   = (rs2_i == '0);
    assign div_ovf    = div_signed && (rs1_i == MOST_NEG) && (rs2_i == ALL_ONES);
    assign special    = div_op && (div_zero || div_ovf);

    muldiv_sign_fix #(.W(XLEN)) u_fix_a (
        .value  (rs1_i),
        .negate (a_neg),
        .fixed  (mag_a)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_b (
        .value  (rs2_i),
        .negate (b_neg),
        .fixed  (mag_b)
    );

    // One multiply iteration: add the shifted multiplicand for each of the
    // MUL_STEP low multiplier bits that are set
    always_comb begin
        prod_step = prod;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) begin
                prod_step = prod_step + (mcand << i);
            end
        end
    end

    // One restoring-divide iteration: bring down the next dividend bit and
    // keep the subtraction only if it did not borrow
    always_comb begin
        trial = {rem, quo[XLEN-1]} - {1'b0, divisor};
        if (!trial[XLEN]) begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_step = {rem[XLEN-2:0], quo[XLEN-1]};
            quo_step = {quo[XLEN-2:0], 1'b0};
        end
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .value  (prod_step),
        .negate (neg_q),
        .fixed  (prod_fixed)
    );

    assign mul_result = (func3_q == FUNCT3_MUL) ? prod_fixed[XLEN-1:0]
                                                : prod_fixed[2*XLEN-1:XLEN];

    assign rem_sel  = (func3_q == FUNCT3_REM) || (func3_q == FUNCT3_REMU);
    assign div_pick = rem_sel ? rem_step : quo_step;

    muldiv_sign_fix #(.W(XLEN)) u_fix_div (
        .value  (div_pick),
        .negate (rem_sel ? rem_neg_q : neg_q),
        .fixed  (div_fixed)
    );

    // Special cases preload their final answers into quo/rem at launch
    assign special_result = rem_sel ? rem : quo;

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; a flush overrides everything else
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = !div_op ? MUL : (special ? SPECIAL : DIV);
                end
            end
            MUL: begin
                busy_o = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            DIV: begin
                busy_o = 1'b1;
                if (cnt == '0) state_next = DONE;
            end
            SPECIAL: begin
                busy_o     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (accept) begin
                    state_next = !div_op ? MUL : (special ? SPECIAL : DIV);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    // Datapath: iterate in MUL/DIV, write the result on the way into DONE
    // (unless flushed), and load fresh operands whenever a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            func3_q   <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                MUL: begin
                    prod   <= prod_step;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == '0 && !flush_i) result_q <= mul_result;
                end
                DIV: begin
                    quo <= quo_step;
                    rem <= rem_step;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == '0 && !flush_i) result_q <= div_fixed;
                end
                SPECIAL: begin
                    if (!flush_i) result_q <= special_result;
                end
                default: ;
            endcase
            if (accept) begin
                func3_q   <= func3_i;
                cnt       <= div_op ? DIV_LAST : MUL_LAST;
                prod      <= '0;
                mcand     <= {{XLEN{1'b0}}, mag_a};
                mplier    <= mag_b;
                divisor   <= mag_b;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                if (special) begin
                    quo <= div_zero ? ALL_ONES : MOST_NEG;
                    rem <= div_zero ? rs1_i : '0;
                end else begin
                    quo <= mag_a;
                    rem <= '0;
                end
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases from the RV32M rules,
// flush/reset/ignored-start/back-to-back scenarios and randomized operations
// checked against a plain-arithmetic reference model. A second instance with
// MUL_STEP=4 covers the faster multiply.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start4;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    logic        busy4, done4;
    logic [31:0] result4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_result;

    muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .func3_i  (func3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start4),
        .func3_i  (func3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .busy_o   (busy4),
        .done_o   (done4),
        .result_o (result4)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M results straight from the ISA definition
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, sub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sub = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * sub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Reference: edges from accepting start to done_o
    function automatic int refLatency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b, input int step);
        if (!f[2]) return 32 / step + 1;
        if (b == 0) return 2;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
        func3 = f;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
    endtask

    // Counts edges until done_o (bounded) and notes any non-busy cycle before it
    task automatic waitDone(output int cycles, output bit busy_ok);
        cycles  = 0;
        busy_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected);
        int cycles;
        bit busy_ok;
        @(negedge clk);
        applyStimulus(f, a, b);
        waitDone(cycles, busy_ok);
        checkOutput({tag, " result"}, result, expected);
        checkOutput({tag, " latency"}, cycles, refLatency(f, a, b, 1));
        checkOutput({tag, " busy"}, busy_ok, 1);
        last_result = expected;
    endtask

    task automatic runOp4(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
        int cycles;
        @(negedge clk);
        func3  = f;
        rs1    = a;
        rs2    = b;
        start4 = 1'b1;
        cycles = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            start4 = 1'b0;
            cycles++;
            if (done4) break;
        end
        checkOutput({tag, " result"}, result4, expected);
        checkOutput({tag, " latency"}, cycles, refLatency(f, a, b, 4));
    endtask

    initial begin
        int cycles;
        bit busy_ok;
        bit saw_done;
        logic [2:0]  f;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; start4 = 1'b0; flush = 1'b0;
        func3 = '0; rs1 = '0; rs2 = '0; last_result = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        runOp("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        runOp4("MUL4 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        runOp("MULHU -1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("MULH -1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        runOp("MULHSU -1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runOp("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runOp("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'h0000_000E);
        runOp("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'h0000_0002);
        runOp("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        runOp("REM 5/0", 3'd6, 32'd5, 32'd0, 32'h0000_0005);
        runOp("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runOp("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Flush at cycle 10 of a divide: idle at 11, no done, result kept
        @(negedge clk);
        applyStimulus(3'd4, 32'd1000, 32'd3);
        repeat (10) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush busy", busy, 0);
        saw_done = done;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("flush no done", saw_done, 0);
        checkOutput("flush result kept", result, last_result);

        // A start pulsed at cycle 5 of a multiply is ignored
        @(negedge clk);
        applyStimulus(3'd0, 32'h0001_2345, 32'hFFFF_0F0F);
        cycles = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
            if (done) break;
            if (cycles == 5) applyStimulus(3'd5, 32'd77, 32'd5);
        end
        checkOutput("ignored start result", result, refModel(3'd0, 32'h0001_2345, 32'hFFFF_0F0F));
        checkOutput("ignored start latency", cycles, 33);
        @(posedge clk);
        #1;
        checkOutput("ignored start no relaunch", busy, 0);

        // Synchronous reset in the middle of a multiply
        @(negedge clk);
        applyStimulus(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (8) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset result", result, 0);

        // Back-to-back: launch DIVU 9/3 in the MULHU done cycle
        @(negedge clk);
        applyStimulus(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        waitDone(cycles, busy_ok);
        checkOutput("b2b first result", result, refModel(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        checkOutput("b2b first done", done, 1);
        applyStimulus(3'd5, 32'd9, 32'd3);
        waitDone(cycles, busy_ok);
        checkOutput("b2b second result", result, 32'h0000_0003);
        checkOutput("b2b second latency", cycles, 33);
        checkOutput("b2b second busy", busy_ok, 1);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = $urandom_range(0, 50);
                    b = $urandom_range(1, 9);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: begin a = $urandom; b = 32'd0; end
                default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            endcase
            runOp($sformatf("rand%0d f%0d", n, f), f, a, b, refModel(f, a, b));
        end
        for (int n = 0; n < 8; n++) begin
            f = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            runOp4($sformatf("rand4_%0d f%0d", n, f), f, a, b, refModel(f, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
